// File: rtl/button_reader_if.sv
// Signal bundle between the button reader and its consumer.
// It carries the raw pin in and the debounced level and event pulses out.
interface button_reader_if #(
    parameter int COUNT_W = 8
);
    logic               btn_pin;
    logic               pressed;
    logic               press;
    logic               release_p;     // "release" is a reserved word in SystemVerilog
    logic               long_press;
    logic [COUNT_W-1:0] press_count;

    modport slave (
        input  btn_pin,
        output pressed, press, release_p, long_press, press_count
    );

    modport master (
        output btn_pin,
        input  pressed, press, release_p, long_press, press_count
    );
endinterface

// File: rtl/button_reader.sv
// Push-button reader. The raw pin passes through a 2-flop synchronizer and
// polarity normalisation, then a debounce FSM that produces a level and one-cycle event pulses.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | pressed level seen, counting stable cycles before accepting
// PRESSED      | press accepted, hold time running toward long-press
// RELEASE_WAIT | released level seen, counting stable cycles before accepting
module button_reader #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter int COUNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    button_reader_if.slave   bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic              PIN_IDLE = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 armed_q, armed_d;
    logic                 pressed_q, pressed_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 long_q, long_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 btn_s;
    logic [HOLD_W-1:0]    hold_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= PIN_IDLE;
            sync2_q    <= PIN_IDLE;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            armed_q    <= 1'b0;
            pressed_q  <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            armed_q    <= armed_d;
            pressed_q  <= pressed_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            count_q    <= count_d;
        end
    end

    assign btn_s    = sync2_q ^ ACTIVE_LOW;
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

    always_comb begin
        sync1_d    = bus.btn_pin;
        sync2_d    = sync1_q;
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        armed_d    = armed_q;
        pressed_d  = pressed_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (btn_s) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    pressed_d  = 1'b1;
                    count_d    = count_q + 1'b1;
                    hold_cnt_d = '0;
                    armed_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                hold_cnt_d = hold_inc;
                if (armed_q && hold_cnt_q == HOLD_MAX) begin
                    long_d  = 1'b1;
                    armed_d = 1'b0;
                end
                if (!btn_s) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                // Hold time keeps running so a bounce on release cannot hide a long press.
                hold_cnt_d = hold_inc;
                if (armed_q && hold_cnt_q == HOLD_MAX) begin
                    long_d  = 1'b1;
                    armed_d = 1'b0;
                end
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) deb_cnt_d = '0;
    end

    assign bus.pressed     = pressed_q;
    assign bus.press       = press_q;
    assign bus.release_p   = release_q;
    assign bus.long_press  = long_q;
    assign bus.press_count = count_q;
endmodule
